// File: rtl/block_address_generator.sv
// Block address generator: SRAM address + DP-RAM index stream for one BLK x BLK block per start.
// Latency: addr_valid rises the cycle after start, then one beat per cycle; done one cycle after the last beat.
// Backpressure: addr/dpram_addr/plane hold while addr_valid & !addr_ready; no beat skipped or repeated.
//
// Ports: clock, reset (async, active-high), clear (sync abort + pointer reset), start, mode (0 fetch,
//   1 write), addr_ready -> addr, addr_valid, dpram_addr, plane (0 Y, 1 U, 2 V), busy, done, frame_done.
// Fetch and write keep separate block pointers (Y, U, V in raster order) so a fetch of block k+1 can
// overlap the write-back of block k.
// Optional macro BLOCK_ADDR_TRANSPOSE_EN: fetch dpram_addr becomes column-major (c*BLK + r).
module block_address_generator #(
   parameter int ADDR_W       = 18,
   parameter int BLK_LOG2     = 3,
   parameter int Y_COLS       = 320,
   parameter int ROWS         = 240,
   parameter int FETCH_Y_BASE = 76800,
   parameter int FETCH_U_BASE = 153600,
   parameter int FETCH_V_BASE = 192000,
   parameter int WRITE_Y_BASE = 0,
   parameter int WRITE_U_BASE = 38400,
   parameter int WRITE_V_BASE = 57600
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  addr_ready,
   output logic [ADDR_W-1:0]     addr,
   output logic                  addr_valid,
   output logic [2*BLK_LOG2-1:0] dpram_addr,
   output logic [1:0]            plane,
   output logic                  busy,
   output logic                  done,
   output logic                  frame_done
);

   localparam int BLK = 1 << BLK_LOG2;

   typedef logic [ADDR_W-1:0] word_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // Block pointer. row_addr is the address of block column 0 in the current block row,
   // blk_addr the address of the block itself; both are stepped with adders only.
   typedef struct packed {
      logic [1:0] pl;
      word_t      brow;
      word_t      bcol;
      word_t      row_addr;
      word_t      blk_addr;
   } ptr_t;

   localparam word_t ONE         = word_t'(1);
   localparam word_t Y_BCOL_LAST = word_t'(Y_COLS / BLK - 1);
   localparam word_t C_BCOL_LAST = word_t'(Y_COLS / (2 * BLK) - 1);
   localparam word_t BROW_LAST   = word_t'(ROWS / BLK - 1);
   localparam word_t F_STEP      = word_t'(BLK);
   localparam word_t W_STEP      = word_t'(BLK / 2);

   localparam logic [BLK_LOG2-1:0] RC_ONE  = {{(BLK_LOG2-1){1'b0}}, 1'b1};
   localparam logic [BLK_LOG2-1:0] C_MAX_F = '1;
   localparam logic [BLK_LOG2-1:0] C_MAX_W = {1'b0, {(BLK_LOG2-1){1'b1}}};

   // Row stride in words: fetch stores one sample per word, write packs two.
   function automatic word_t stride_of(input logic m, input logic [1:0] pl);
      word_t s;
      s = (pl == 2'd0) ? word_t'(Y_COLS) : word_t'(Y_COLS / 2);
      return m ? (s >> 1) : s;
   endfunction

   function automatic word_t base_of(input logic m, input logic [1:0] pl);
      word_t b;
      case ({m, pl})
         3'b000:  b = word_t'(FETCH_Y_BASE);
         3'b001:  b = word_t'(FETCH_U_BASE);
         3'b010:  b = word_t'(FETCH_V_BASE);
         3'b100:  b = word_t'(WRITE_Y_BASE);
         3'b101:  b = word_t'(WRITE_U_BASE);
         3'b110:  b = word_t'(WRITE_V_BASE);
         default: b = '0;
      endcase
      return b;
   endfunction

   function automatic logic last_bcol(input ptr_t p);
      return p.bcol == ((p.pl == 2'd0) ? Y_BCOL_LAST : C_BCOL_LAST);
   endfunction

   function automatic ptr_t ptr_init(input logic m);
      ptr_t p;
      p          = '0;
      p.row_addr = base_of(m, 2'd0);
      p.blk_addr = p.row_addr;
      return p;
   endfunction

   function automatic ptr_t advance(input ptr_t p, input logic m);
      ptr_t  n;
      word_t nrow;
      n    = p;
      // One block row down is BLK sample rows, i.e. stride << BLK_LOG2.
      nrow = p.row_addr + (stride_of(m, p.pl) << BLK_LOG2);
      if (!last_bcol(p)) begin
         n.bcol     = p.bcol + ONE;
         n.blk_addr = p.blk_addr + (m ? W_STEP : F_STEP);
      end else if (p.brow != BROW_LAST) begin
         n.bcol     = '0;
         n.brow     = p.brow + ONE;
         n.row_addr = nrow;
         n.blk_addr = nrow;
      end else begin
         n.bcol     = '0;
         n.brow     = '0;
         n.pl       = (p.pl == 2'd2) ? 2'd0 : p.pl + 2'd1;
         n.row_addr = base_of(m, n.pl);
         n.blk_addr = n.row_addr;
      end
      return n;
   endfunction

   state_t                state_q, state_d;
   ptr_t                  fptr, wptr, sel_ptr;
   logic                  mode_q, last_blk_q;
   word_t                 row_q, stride_q;
   logic [BLK_LOG2-1:0]   r_q, c_q, c_max;
   logic                  beat, last_beat;

   assign sel_ptr   = mode ? wptr : fptr;
   assign c_max     = mode_q ? C_MAX_W : C_MAX_F;
   assign beat      = (state_q == S_RUN) && addr_ready;
   assign last_beat = (r_q == C_MAX_F) && (c_q == c_max);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      addr_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: if (start && !clear) state_d = S_RUN;
         S_RUN: begin
            addr_valid = 1'b1;
            busy       = 1'b1;
            if (clear)                  state_d = S_IDLE;
            else if (beat && last_beat) state_d = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            frame_done = last_blk_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fptr       <= ptr_init(1'b0);
         wptr       <= ptr_init(1'b1);
         mode_q     <= 1'b0;
         last_blk_q <= 1'b0;
         addr       <= '0;
         row_q      <= '0;
         stride_q   <= '0;
         r_q        <= '0;
         c_q        <= '0;
         plane      <= '0;
      end else if (clear) begin
         fptr <= ptr_init(1'b0);
         wptr <= ptr_init(1'b1);
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               mode_q     <= mode;
               addr       <= sel_ptr.blk_addr;
               row_q      <= sel_ptr.blk_addr;
               stride_q   <= stride_of(mode, sel_ptr.pl);
               r_q        <= '0;
               c_q        <= '0;
               plane      <= sel_ptr.pl;
               last_blk_q <= (sel_ptr.pl == 2'd2) && last_bcol(sel_ptr) &&
                             (sel_ptr.brow == BROW_LAST);
            end
            S_RUN: if (beat) begin
               if (c_q == c_max) begin
                  c_q   <= '0;
                  r_q   <= r_q + RC_ONE;
                  row_q <= row_q + stride_q;
                  addr  <= row_q + stride_q;
               end else begin
                  c_q  <= c_q + RC_ONE;
                  addr <= addr + ONE;
               end
            end
            S_DONE: begin
               if (mode_q) wptr <= advance(wptr, 1'b1);
               else        fptr <= advance(fptr, 1'b0);
            end
            default: ;
         endcase
      end
   end

   // Write bursts index sample pairs, so only BLK_LOG2-1 column bits are meaningful.
   always_comb begin
      if (mode_q) begin
         dpram_addr = {1'b0, r_q, c_q[BLK_LOG2-2:0]};
      end else begin
`ifdef BLOCK_ADDR_TRANSPOSE_EN
         dpram_addr = {c_q, r_q};
`else
         dpram_addr = {r_q, c_q};
`endif
      end
   end

endmodule
